// File: rtl/neural_acq_top_core_if.sv
// rtl/neural_acq_top_core_if.sv - packet stream and register bus bundle for neural_acq_top_core
interface neural_acq_top_core_if;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  csr_addr;
    logic        csr_write;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (
        output dout, dout_valid, csr_rdata,
        input  dout_ready, csr_addr, csr_write, csr_wdata
    );

    modport slave (
        input  dout, dout_valid, csr_rdata,
        output dout_ready, csr_addr, csr_write, csr_wdata
    );
endinterface

// File: rtl/neural_acq_top_core.sv
// rtl/neural_acq_top_core.sv - multichannel sample snapshot, per-channel packet sweep into 32-deep FWFT FIFO
// NEURAL_ACQ_TS_EN: when defined, a free-running 32-bit timestamp is stamped into packets and readable at CSR 0x2.
module neural_acq_top_core #(
    parameter int DATA_WIDTH   = 16,
    parameter int CH_ID_WIDTH  = 4,
    parameter int NUM_CHANNELS = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [DATA_WIDTH-1:0] sensor_data_in [NUM_CHANNELS],
    input  logic                  sensor_valid_all,
    neural_acq_top_core_if.master bus
);
    localparam int FIFO_DEPTH = 32;
    localparam int PTR_W      = 5;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;
    state_t state_q, state_d;

    logic                   ctrl_en, sticky_drop;
    logic [31:0]            frame_count, drop_count, ts_now, snap_ts;
    logic [DATA_WIDTH-1:0]  snap [NUM_CHANNELS];
    logic [CH_ID_WIDTH-1:0] sweep_idx;
    logic [63:0]            fifo_mem [FIFO_DEPTH];
    logic [63:0]            pkt_in;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         fifo_count;
    logic fifo_empty, fifo_full, push, pop, capture, drop, sweep_last, drop_clr;
    logic unused_wdata;

`ifdef NEURAL_ACQ_TS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ts_now <= 32'd0;
        else            ts_now <= ts_now + 32'd1;
    end
`else
    assign ts_now = 32'd0;
`endif

    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop          = !fifo_empty && bus.dout_ready;
    assign sweep_last   = (sweep_idx == CH_ID_WIDTH'(NUM_CHANNELS - 1));
    assign drop_clr     = bus.csr_write && (bus.csr_addr == 3'h1) && bus.csr_wdata[3];
    assign pkt_in       = {snap_ts, 4'(sweep_idx), 16'(snap[sweep_idx]), 12'h000};
    assign unused_wdata = ^{bus.csr_wdata[31:4], bus.csr_wdata[2:1]};

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sensor_valid_all && ctrl_en) begin
                    capture = 1'b1;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                drop = sensor_valid_all && ctrl_en;
                // A pop in the same cycle frees a slot, so a full FIFO need not stall.
                if (!fifo_full || pop) begin
                    push = 1'b1;
                    if (sweep_last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            ctrl_en     <= 1'b0;
            sticky_drop <= 1'b0;
            frame_count <= 32'd0;
            drop_count  <= 32'd0;
            snap_ts     <= 32'd0;
            sweep_idx   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) snap[i] <= '0;
        end else begin
            state_q <= state_d;
            if (bus.csr_write && bus.csr_addr == 3'h0) ctrl_en <= bus.csr_wdata[0];
            if (capture) begin
                snap_ts     <= ts_now;
                frame_count <= frame_count + 32'd1;
                sweep_idx   <= '0;
                for (int i = 0; i < NUM_CHANNELS; i++) snap[i] <= sensor_data_in[i];
            end else if (push) begin
                sweep_idx <= sweep_last ? '0 : sweep_idx + CH_ID_WIDTH'(1);
            end
            // A drop landing in the same cycle as a clear is kept rather than lost.
            if (drop) begin
                sticky_drop <= 1'b1;
                if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
            end else if (drop_clr) begin
                sticky_drop <= 1'b0;
                drop_count  <= 32'd0;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr] <= pkt_in;
    end

    assign bus.dout_valid = !fifo_empty;
    assign bus.dout       = fifo_empty ? 64'd0 : fifo_mem[rd_ptr];

    always_comb begin
        bus.csr_rdata = 32'd0;
        case (bus.csr_addr)
            3'h0:    bus.csr_rdata = {31'd0, ctrl_en};
            3'h1:    bus.csr_rdata = {28'd0, sticky_drop, fifo_full, fifo_empty, (state_q == S_SWEEP)};
            3'h2:    bus.csr_rdata = ts_now;
            3'h3:    bus.csr_rdata = frame_count;
            3'h4:    bus.csr_rdata = drop_count;
            default: bus.csr_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_neural_acq_top_core.sv
// tb/tb_neural_acq_top_core.sv - directed self-checking bench for neural_acq_top_core
module tb_neural_acq_top_core;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] sensor_data_in [16];
    logic        sensor_valid_all;
    logic [31:0] tb_ts;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    neural_acq_top_core_if bus ();

    neural_acq_top_core #(.DATA_WIDTH(16), .CH_ID_WIDTH(4), .NUM_CHANNELS(16)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .sensor_data_in   (sensor_data_in),
        .sensor_valid_all (sensor_valid_all),
        .bus              (bus.master)
    );

    // Reference cycle counter: counts clock edges since reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tb_ts <= 32'd0;
        else            tb_ts <= tb_ts + 32'd1;
    end

    function automatic logic [31:0] ts_expect();
`ifdef NEURAL_ACQ_TS_EN
        return tb_ts;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [63:0] pkt(input logic [31:0] ts, input int ch, input logic [15:0] d);
        logic [3:0] c4;
        c4 = ch[3:0];
        return {ts, c4, d, 12'h000};
    endfunction

    task automatic set_data(input logic [15:0] base, input logic [15:0] step);
        for (int i = 0; i < 16; i++) sensor_data_in[i] = base + 16'(i) * step;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        bus.csr_write = 1'b1;
        @(negedge sys_clk);
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        bus.csr_addr = a;
        #1;
        d = bus.csr_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_v [6];
        exp_v = '{32'h0, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0};
        sys_rst_n = 1'b0; sensor_valid_all = 1'b0; bus.dout_ready = 1'b0;
        bus.csr_write = 1'b0; bus.csr_addr = 3'h0; bus.csr_wdata = 32'h0;
        set_data(16'h0, 16'h0);
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_dout: got valid=%b dout=%h expected valid=0 dout=0", bus.dout_valid, bus.dout);
        end
        for (int a = 0; a < 6; a++) begin
            csr_rd(a[2:0], v);
            tests_run++;
            if (v !== exp_v[a]) begin
                tests_failed++;
                $display("FAIL reset_csr%0d: got %h expected %h", a, v, exp_v[a]);
            end
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_disabled();
        int seen = 0;
        logic [31:0] v;
        set_data(16'h0, 16'h100);
        bus.dout_ready = 1'b1;
        sensor_valid_all = 1'b1;
        @(negedge sys_clk);
        sensor_valid_all = 1'b0;
        repeat (200) begin
            @(negedge sys_clk);
            if (bus.dout_valid) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL disabled_no_packets: got %0d valid cycles expected 0", seen);
        end
        csr_rd(3'h3, v);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL disabled_frame_count: got %h expected 0", v);
        end
    endtask

    task automatic test_frame();
        logic [31:0] v, ets;
        csr_wr(3'h0, 32'h1);
        csr_rd(3'h0, v);
        tests_run++;
        if (v !== 32'h1) begin
            tests_failed++;
            $display("FAIL ctrl_readback: got %h expected 1", v);
        end
        set_data(16'h0, 16'h100);
        bus.dout_ready = 1'b1;
        sensor_valid_all = 1'b1;
        ets = ts_expect();
        @(negedge sys_clk);
        sensor_valid_all = 1'b0;
        tests_run++;
        if (bus.dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_n1: got valid=%b expected 0", bus.dout_valid);
        end
        @(negedge sys_clk);
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== pkt(ets, k, 16'(k * 'h100))) begin
                tests_failed++;
                $display("FAIL frame_pkt%0d: got valid=%b dout=%h expected %h", k, bus.dout_valid, bus.dout, pkt(ets, k, 16'(k * 'h100)));
            end
            @(negedge sys_clk);
        end
        tests_run++;
        if (bus.dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_drained: got valid=%b expected 0", bus.dout_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] v, ets;
        logic [63:0] held;
        int unstable = 0;
        set_data(16'hAAAA, 16'h0);
        bus.dout_ready = 1'b0;
        sensor_valid_all = 1'b1;
        ets = ts_expect();
        @(negedge sys_clk);
        sensor_valid_all = 1'b0;
        @(negedge sys_clk);
        held = bus.dout;
        tests_run++;
        if (held !== pkt(ets, 0, 16'hAAAA)) begin
            tests_failed++;
            $display("FAIL stall_first: got %h expected %h", held, pkt(ets, 0, 16'hAAAA));
        end
        repeat (40) begin
            @(negedge sys_clk);
            if (bus.dout !== held || bus.dout_valid !== 1'b1) unstable++;
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable);
        end
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== pkt(ets, k, 16'hAAAA)) begin
                tests_failed++;
                $display("FAIL stall_pkt%0d: got valid=%b dout=%h expected %h", k, bus.dout_valid, bus.dout, pkt(ets, k, 16'hAAAA));
            end
            @(negedge sys_clk);
        end
        csr_rd(3'h3, v);
        tests_run++;
        if (v !== 32'd2) begin
            tests_failed++;
            $display("FAIL stall_frame_count: got %h expected 2", v);
        end
    endtask

    task automatic test_drop();
        logic [31:0] v;
        int cnt = 0;
        set_data(16'h0123, 16'h1);
        bus.dout_ready = 1'b1;
        sensor_valid_all = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            if (bus.dout_valid) cnt++;
            sensor_valid_all = (c == 2);
        end
        tests_run++;
        if (cnt != 16) begin
            tests_failed++;
            $display("FAIL drop_pkt_count: got %0d expected 16", cnt);
        end
        csr_rd(3'h4, v);
        tests_run++;
        if (v !== 32'd1) begin
            tests_failed++;
            $display("FAIL drop_count: got %h expected 1", v);
        end
        csr_rd(3'h1, v);
        tests_run++;
        if (v !== 32'hA) begin
            tests_failed++;
            $display("FAIL drop_status: got %h expected a", v);
        end
        csr_rd(3'h3, v);
        tests_run++;
        if (v !== 32'd3) begin
            tests_failed++;
            $display("FAIL drop_frame_count: got %h expected 3", v);
        end
        csr_wr(3'h1, 32'h8);
        csr_rd(3'h4, v);
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL drop_clear_count: got %h expected 0", v);
        end
        csr_rd(3'h1, v);
        tests_run++;
        if (v !== 32'h2) begin
            tests_failed++;
            $display("FAIL drop_clear_status: got %h expected 2", v);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] v;
        logic [31:0] ets [3];
        logic [63:0] exp_p;
        int got = 0;
        int errs = 0;
        bus.dout_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            set_data(16'(f * 'h1000), 16'h1);
            sensor_valid_all = 1'b1;
            ets[f] = ts_expect();
            @(negedge sys_clk);
            sensor_valid_all = 1'b0;
            repeat (20) @(negedge sys_clk);
        end
        csr_rd(3'h1, v);
        tests_run++;
        if (v !== 32'h5) begin
            tests_failed++;
            $display("FAIL full_status: got %h expected 5", v);
        end
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 200 && got < 48; c++) begin
            if (bus.dout_valid === 1'b1) begin
                exp_p = pkt(ets[got / 16], got % 16, 16'((got / 16) * 'h1000 + got % 16));
                if (bus.dout !== exp_p) begin
                    if (errs == 0) $display("FAIL full_order_pkt%0d: got %h expected %h", got, bus.dout, exp_p);
                    errs++;
                end
                got++;
            end
            @(negedge sys_clk);
        end
        tests_run++;
        if (got != 48) begin
            tests_failed++;
            $display("FAIL full_pkt_count: got %0d expected 48", got);
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL full_order: got %0d mismatching packets expected 0", errs);
        end
        csr_rd(3'h3, v);
        tests_run++;
        if (v !== 32'd6) begin
            tests_failed++;
            $display("FAIL full_frame_count: got %h expected 6", v);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] v;
        logic [31:0] exp_v [5];
        int seen = 0;
        exp_v = '{32'h0, 32'h2, 32'h0, 32'h0, 32'h0};
        set_data(16'h0005, 16'h0);
        bus.dout_ready = 1'b0;
        sensor_valid_all = 1'b1;
        @(negedge sys_clk);
        sensor_valid_all = 1'b0;
        repeat (5) @(negedge sys_clk);
        tests_run++;
        if (bus.dout_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre_valid: got %b expected 1", bus.dout_valid);
        end
        sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 64'd0) begin
            tests_failed++;
            $display("FAIL midrst_dout: got valid=%b dout=%h expected valid=0 dout=0", bus.dout_valid, bus.dout);
        end
        for (int a = 0; a < 5; a++) begin
            csr_rd(a[2:0], v);
            tests_run++;
            if (v !== exp_v[a]) begin
                tests_failed++;
                $display("FAIL midrst_csr%0d: got %h expected %h", a, v, exp_v[a]);
            end
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bus.dout_ready = 1'b1;
        repeat (20) begin
            @(negedge sys_clk);
            if (bus.dout_valid) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL midrst_after: got %0d valid cycles expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_frame();
        test_stall();
        test_drop();
        test_fifo_full();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/neural_acq_top_core.md
NEURAL_ACQ_TOP_CORE -- requirements
Module: neural_acq_top

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning sample width.
REQ-002 The block SHALL have parameter CH_ID_WIDTH, default 4, meaning channel ID field width.
REQ-003 The block SHALL have parameter NUM_CHANNELS, default 16, meaning parallel sensor channels.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low; ports are sys_clk and sys_rst_n.
REQ-005 sys_clk  input  1  sole clock; all logic rises on posedge.
REQ-006 sys_rst_n  input  1  asynchronous active-low reset.
REQ-007 sensor_data_in  input  DATA_WIDTH x NUM_CHANNELS unpacked array  per-channel samples.
REQ-008 sensor_valid_all  input  1  all channels valid this cycle (capture strobe).
REQ-009 dout  output  64  packet: [63:32] timestamp, [31:28] channel, [27:12] data, [11:0] zero.
REQ-010 dout_valid  output  1  packet valid.
REQ-011 dout_ready  input  1  consumer accepts packet.
REQ-012 csr_addr  input  3  register address.
REQ-013 csr_write  input  1  write strobe.
REQ-014 csr_wdata  input  32  write data.
REQ-015 csr_rdata  output  32  combinational read data for csr_addr.

Function
REQ-016 CSR map SHALL be: 0x0 CTRL (bit0 enable, RW); 0x1 STATUS (RO: bit0 sweep busy, bit1 FIFO empty, bit2 FIFO full, bit3 sticky drop); 0x2 TIMESTAMP (RO); 0x3 FRAME_COUNT (RO); 0x4 DROP_COUNT (RO); others read 0, writes ignored.
REQ-017 Writing 0x1 with wdata bit3=1 SHALL clear sticky drop and DROP_COUNT.
REQ-018 A 32-bit timestamp counter SHALL increment every cycle from reset, wrapping 0xFFFFFFFF->0.
REQ-019 Frame capture: sensor_valid_all=1 with enable=1 in state IDLE SHALL latch all channels and the timestamp into a snapshot, enter SWEEP, and increment FRAME_COUNT.
REQ-020 sensor_valid_all with enable=0 SHALL be ignored (no packets, no counts).
REQ-021 sensor_valid_all with enable=1 in SWEEP SHALL drop the frame, increment DROP_COUNT (saturating) and set sticky drop.
REQ-022 SWEEP SHALL push one packet per cycle into the output FIFO, channel 0 to NUM_CHANNELS-1 ascending, all with the latched timestamp; after the last push return to IDLE.
REQ-023 Sweep SHALL stall (no push, index held) while FIFO is full; no packet is ever lost.
REQ-024 Clearing enable mid-sweep SHALL NOT abort the sweep.
REQ-025 Output FIFO SHALL be 32 entries, first-word-fall-through; dout_valid=1 iff non-empty; pop on dout_valid&&dout_ready; dout held stable while valid and not ready.
REQ-026 Simultaneous push and pop when full SHALL be allowed (pop frees the slot same cycle).
REQ-027 Latency: capture cycle N -> channel 0 on dout with dout_valid=1 at cycle N+2 given empty FIFO.
REQ-028 With dout_ready held 1, a frame SHALL drain in 16 consecutive cycles.

Reset
REQ-029 Reset SHALL set enable=0, state IDLE, FIFO empty, dout_valid=0, dout=0, timestamp=0, FRAME_COUNT=0, DROP_COUNT=0, sticky drop=0.
REQ-030 Reset mid-sweep SHALL discard snapshot and FIFO contents immediately.

Configuration
REQ-031 Macro NEURAL_ACQ_TS_EN defined: timestamp counter present, dout[63:32] and CSR 0x2 carry it; undefined: no counter, dout[63:32]=0 and CSR 0x2 reads 0.

Verification
REQ-032 Reset, enable=0, strobe with data i*0x100 -> no dout_valid for 200 cycles, FRAME_COUNT=0.
REQ-033 Write CTRL=1, strobe data i*0x100 -> 16 packets ch 0..15, data 0x0000..0x0F00, identical timestamp, first at N+2.
REQ-034 Strobe all 0xAAAA, dout_ready=0 for 40 cycles then 1 -> 16 packets of 0xAAAA, dout stable while stalled, FRAME_COUNT=2.
REQ-035 Two strobes 3 cycles apart -> second dropped, DROP_COUNT=1, STATUS bit3=1; write 0x1 bit3 -> both cleared.
REQ-036 dout_ready=0, three spaced frames -> FIFO full after 32, sweep stalls; release -> all 48 packets in order.
REQ-037 Assert sys_rst_n=0 mid-sweep -> dout_valid=0 immediately, all CSRs at reset values.
